// File: rtl/taxi_pcie_us_msi_req.sv
`default_nettype none
// ============================================================================
// Module   : taxi_pcie_us_msi_req
// Brief    : Round-robin MSI request generator for the UltraScale+ PCIe
//            cfg_interrupt_msi_* interface with mask, aliasing and retry.
// Revision : 1.0
// ============================================================================
module taxi_pcie_us_msi_req #(
    parameter int IRQ_N       = 32,
    parameter int RETRY_DELAY = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_N-1:0] irq_req,
    input  logic [3:0]       cfg_interrupt_msi_enable,
    input  logic [11:0]      cfg_interrupt_msi_mmenable,
    input  logic             cfg_interrupt_msi_mask_update,
    input  logic [31:0]      cfg_interrupt_msi_data,
    output logic [1:0]       cfg_interrupt_msi_select,
    output logic [31:0]      cfg_interrupt_msi_int,
    input  logic             cfg_interrupt_msi_sent,
    input  logic             cfg_interrupt_msi_fail,
    output logic [31:0]      cfg_interrupt_msi_pending_status,
    output logic             cfg_interrupt_msi_pending_status_data_enable,
    output logic [1:0]       cfg_interrupt_msi_pending_status_function_num,
    output logic [2:0]       cfg_interrupt_msi_attr,
    output logic             cfg_interrupt_msi_tph_present,
    output logic [1:0]       cfg_interrupt_msi_tph_type,
    output logic [7:0]       cfg_interrupt_msi_tph_st_tag,
    output logic [7:0]       cfg_interrupt_msi_function_number,
    output logic             stat_sent,
    output logic             stat_fail
);

    localparam int C_IW   = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
    localparam int C_CMAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
    localparam int C_CW   = $clog2(C_CMAX + 1);
    localparam logic [C_CW-1:0] C_TO_LAST = C_CW'(TIMEOUT - 1);
    localparam logic [C_CW-1:0] C_RD_LAST = C_CW'(RETRY_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_BACKOFF = 2'd3
    } state_t;

    state_t            state_q;
    logic [IRQ_N-1:0]  pending_q, pending_d;
    logic [31:0]       mask_q;
    logic [C_IW-1:0]   rr_q, sel_q;
    logic [C_CW-1:0]   cnt_q;
    logic [31:0]       msi_int_q, pstat_q;
    logic              pstat_de_q, sent_q, fail_q;

    logic [2:0]        w_mme;
    logic [5:0]        w_amask_full;
    logic [4:0]        w_amask;
    logic [IRQ_N-1:0]  w_elig;
    logic              w_pick_vld;
    logic [C_IW-1:0]   w_pick;
    logic [31:0]       w_pstat;
    logic              w_retry;
    logic              w_unused;

    assign w_unused = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    function automatic logic [4:0] vec_of(input int idx, input logic [4:0] am);
        return 5'(idx) & am;
    endfunction

    // Sources beyond the host-granted vector count fold onto the low vectors.
    always_comb begin
        w_mme        = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
        w_amask_full = (6'd1 << w_mme) - 6'd1;
        w_amask      = w_amask_full[4:0];
    end

    always_comb begin
        w_elig     = '0;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            w_elig[i] = pending_q[i] & cfg_interrupt_msi_enable[0] & ~mask_q[vec_of(i, w_amask)];
        end
        for (int j = 0; j < IRQ_N; j++) begin
            if (!w_pick_vld && w_elig[C_IW'((int'(rr_q) + j) % IRQ_N)]) begin
                w_pick_vld = 1'b1;
                w_pick     = C_IW'((int'(rr_q) + j) % IRQ_N);
            end
        end
    end

    always_comb begin
        w_pstat = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (pending_q[i] && mask_q[vec_of(i, w_amask)]) begin
                w_pstat[vec_of(i, w_amask)] = 1'b1;
            end
        end
    end

    assign w_retry = (state_q == S_WAIT) && !cfg_interrupt_msi_sent &&
                     (cfg_interrupt_msi_fail || cnt_q == C_TO_LAST);

    // A new request on the issuing index overrides the issue-time clear.
    always_comb begin
        pending_d = pending_q | irq_req;
        if (state_q == S_ISSUE) begin
            pending_d[sel_q] = irq_req[sel_q];
        end
        if (w_retry) begin
            pending_d[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            rr_q       <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            msi_int_q  <= '0;
            pstat_q    <= '0;
            pstat_de_q <= 1'b0;
            sent_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pstat_q    <= w_pstat;
            pstat_de_q <= (w_pstat != pstat_q);
            msi_int_q  <= '0;
            sent_q     <= 1'b0;
            fail_q     <= 1'b0;
            if (cfg_interrupt_msi_mask_update) begin
                mask_q <= cfg_interrupt_msi_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        sel_q     <= w_pick;
                        msi_int_q <= 32'd1 << vec_of(int'(w_pick), w_amask);
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rr_q    <= (int'(sel_q) == IRQ_N - 1) ? '0 : sel_q + C_IW'(1);
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cfg_interrupt_msi_sent) begin
                        sent_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (w_retry) begin
                        fail_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_BACKOFF;
                    end else begin
                        cnt_q <= cnt_q + C_CW'(1);
                    end
                end
                S_BACKOFF: begin
                    if (cnt_q == C_RD_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + C_CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_interrupt_msi_int                         = msi_int_q;
    assign cfg_interrupt_msi_pending_status              = pstat_q;
    assign cfg_interrupt_msi_pending_status_data_enable  = pstat_de_q;
    assign stat_sent                                     = sent_q;
    assign stat_fail                                     = fail_q;
    assign cfg_interrupt_msi_select                      = 2'd0;
    assign cfg_interrupt_msi_pending_status_function_num = 2'd0;
    assign cfg_interrupt_msi_attr                        = 3'd0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = 2'd0;
    assign cfg_interrupt_msi_tph_st_tag                  = 8'd0;
    assign cfg_interrupt_msi_function_number             = 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_taxi_pcie_us_msi_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_taxi_pcie_us_msi_req
// Brief    : Directed and randomized bench for taxi_pcie_us_msi_req against a
//            timestamp-based reference model.
// Revision : 1.0
// ============================================================================
module tb_taxi_pcie_us_msi_req;

    localparam int N  = 32;
    localparam int RD = 16;
    localparam int TO = 1024;

    logic        clk;
    logic        rst;
    logic [N-1:0] irq_req;
    logic [3:0]  msi_en;
    logic [11:0] msi_mme;
    logic        mask_upd;
    logic [31:0] mask_data;
    logic        msi_sent, msi_fail;
    logic [1:0]  o_select, o_ps_fn;
    logic [31:0] o_int, o_ps;
    logic        o_ps_de, o_tph_present, o_sent, o_fail;
    logic [2:0]  o_attr;
    logic [1:0]  o_tph_type;
    logic [7:0]  o_tph_st_tag, o_fn;

    taxi_pcie_us_msi_req #(.IRQ_N(N), .RETRY_DELAY(RD), .TIMEOUT(TO)) dut (
        .clk                                          (clk),
        .rst                                          (rst),
        .irq_req                                      (irq_req),
        .cfg_interrupt_msi_enable                     (msi_en),
        .cfg_interrupt_msi_mmenable                   (msi_mme),
        .cfg_interrupt_msi_mask_update                (mask_upd),
        .cfg_interrupt_msi_data                       (mask_data),
        .cfg_interrupt_msi_select                     (o_select),
        .cfg_interrupt_msi_int                        (o_int),
        .cfg_interrupt_msi_sent                       (msi_sent),
        .cfg_interrupt_msi_fail                       (msi_fail),
        .cfg_interrupt_msi_pending_status             (o_ps),
        .cfg_interrupt_msi_pending_status_data_enable (o_ps_de),
        .cfg_interrupt_msi_pending_status_function_num(o_ps_fn),
        .cfg_interrupt_msi_attr                       (o_attr),
        .cfg_interrupt_msi_tph_present                (o_tph_present),
        .cfg_interrupt_msi_tph_type                   (o_tph_type),
        .cfg_interrupt_msi_tph_st_tag                 (o_tph_st_tag),
        .cfg_interrupt_msi_function_number            (o_fn),
        .stat_sent                                    (o_sent),
        .stat_fail                                    (o_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stimulus staged for the next cycle; pulses self-clear after one cycle.
    logic [N-1:0] nx_irq = '0;
    logic [3:0]   nx_en = '0;
    logic [11:0]  nx_mme = '0;
    logic         nx_rst = 1'b0, nx_mupd = 1'b0, nx_sent = 1'b0, nx_fail = 1'b0;
    logic [31:0]  nx_mdata = '0;
    bit           auto_resp = 0;
    int           resp_at = -1, resp_kind = 0;

    // Reference model: pending set, issue timestamps and earliest-next-pick time.
    logic [N-1:0] m_pend;
    logic [31:0]  m_mask, m_int, m_ps;
    bit           m_sent, m_fail, m_de, m_issue;
    int           m_rr, m_sel, m_wait_start, m_pick_ok;
    int           cyc = 0;
    int           de_cnt = 0;
    int           log_cyc[$];
    logic [31:0]  log_val[$];

    function automatic int alias_of(input int i);
        int mm;
        mm = int'(msi_mme[2:0]);
        if (mm > 5) mm = 5;
        return i % (1 << mm);
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_int = '0; m_ps = '0;
        m_sent = 0; m_fail = 0; m_de = 0; m_issue = 0;
        m_rr = 0; m_sel = -1; m_wait_start = 0; m_pick_ok = 0;
    endtask

    task automatic model_update();
        logic [31:0] ps_n, n_int;
        bit          n_sent, n_fail, n_issue;
        int          pick;
        if (rst) begin
            model_reset();
        end else begin
            ps_n = '0;
            for (int i = 0; i < N; i++)
                if (m_pend[i] && m_mask[alias_of(i)]) ps_n[alias_of(i)] = 1'b1;
            pick = -1;
            if (m_sel < 0 && cyc >= m_pick_ok && msi_en[0])
                for (int j = 0; j < N; j++)
                    if (pick < 0 && m_pend[(m_rr + j) % N] && !m_mask[alias_of((m_rr + j) % N)])
                        pick = (m_rr + j) % N;
            n_int = '0; n_sent = 0; n_fail = 0; n_issue = 0;
            if (m_issue) begin
                m_pend[m_sel] = 1'b0;
                m_rr = (m_sel + 1) % N;
                m_wait_start = cyc + 1;
            end else if (m_sel >= 0) begin
                if (msi_sent) begin
                    n_sent = 1; m_sel = -1; m_pick_ok = cyc + 1;
                end else if (msi_fail || (cyc - m_wait_start) == TO - 1) begin
                    n_fail = 1; m_pend[m_sel] = 1'b1; m_sel = -1; m_pick_ok = cyc + 1 + RD;
                end
            end
            m_pend = m_pend | irq_req;
            if (mask_upd) m_mask = mask_data;
            if (pick >= 0) begin
                m_sel = pick; n_int = 32'd1 << alias_of(pick); n_issue = 1;
            end
            m_de = (ps_n != m_ps);
            m_ps = ps_n; m_int = n_int; m_sent = n_sent; m_fail = n_fail; m_issue = n_issue;
        end
    endtask

    task automatic step();
        int r;
        @(negedge clk);
        chk("msi_int", o_int, m_int);
        chk("stat_sent", 32'(o_sent), 32'(m_sent));
        chk("stat_fail", 32'(o_fail), 32'(m_fail));
        chk("pending_status", o_ps, m_ps);
        chk("ps_data_enable", 32'(o_ps_de), 32'(m_de));
        if (o_int != 0) begin
            log_cyc.push_back(cyc);
            log_val.push_back(o_int);
        end
        if (o_ps_de) de_cnt++;
        if (auto_resp) begin
            if (m_issue) begin
                resp_at = cyc + int'($urandom_range(1, 6));
                r = int'($urandom_range(0, 99));
                resp_kind = (r < 70) ? 0 : (r < 88) ? 1 : (r < 98) ? 2 : 3;
            end
            nx_sent = 0; nx_fail = 0;
            if (m_sel >= 0 && !m_issue && cyc == resp_at) begin
                nx_sent = (resp_kind == 0 || resp_kind == 2);
                nx_fail = (resp_kind == 1 || resp_kind == 2);
            end
        end
        rst = nx_rst; irq_req = nx_irq; msi_en = nx_en; msi_mme = nx_mme;
        mask_upd = nx_mupd; mask_data = nx_mdata; msi_sent = nx_sent; msi_fail = nx_fail;
        model_update();
        nx_irq = '0; nx_mupd = 0;
        if (!auto_resp) begin nx_sent = 0; nx_fail = 0; end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_msi(input int limit, output int c, output logic [31:0] v);
        int n0;
        n0 = log_cyc.size(); c = -1; v = '0;
        for (int k = 0; k < limit && log_cyc.size() == n0; k++) step();
        if (log_cyc.size() > n0) begin
            c = log_cyc[n0]; v = log_val[n0];
        end else begin
            chk("msi_wait_expired", 32'(log_cyc.size()), 32'(n0 + 1));
        end
    endtask

    task automatic respond(input int at, input bit s, input bit f);
        while (cyc < at) step();
        nx_sent = s; nx_fail = f;
        step();
    endtask

    task automatic do_reset();
        nx_rst = 1; step(); step();
        nx_rst = 0; step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, c2, a, m, n0, d0;
        logic [31:0] v, v2;
        logic [31:0] rr_exp [3];
        rr_exp[0] = 32'h1; rr_exp[1] = 32'h10; rr_exp[2] = 32'h20;
        rst = 1; irq_req = '0; msi_en = '0; msi_mme = '0; mask_upd = 0;
        mask_data = '0; msi_sent = 0; msi_fail = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Single request
        nx_en = 4'h1; nx_mme = 12'd5; step();
        a = cyc; nx_irq = 32'h8; step();
        wait_msi(20, c, v);
        chk("t1_latency", 32'(c - a), 32'd2);
        chk("t1_vector", v, 32'h8);
        respond(c + 5, 1, 0);
        step();
        chk("t1_stat_sent", 32'(o_sent), 32'd1);

        // Round robin with pointer wrap
        do_reset();
        nx_irq = 32'h31; step();
        for (int k = 0; k < 3; k++) begin
            wait_msi(20, c, v);
            chk("t2_rr_order", v, rr_exp[k]);
            respond(c + 3, 1, 0);
        end
        nx_irq = 32'h21; step();
        wait_msi(20, c, v);
        chk("t2_rr_wrap", v, 32'h1);
        respond(c + 3, 1, 0);
        wait_msi(20, c, v);
        chk("t2_rr_wrap_next", v, 32'h20);
        respond(c + 3, 1, 0);

        // Fail and timeout retry
        do_reset();
        nx_irq = 32'h4; step();
        wait_msi(20, c, v);
        m = c + 3;
        respond(m, 0, 1);
        wait_msi(40, c2, v2);
        chk("t3_fail_reissue_gap", 32'(c2 - m), 32'(RD + 2));
        chk("t3_fail_reissue_vec", v2, 32'h4);
        respond(c2 + 2, 1, 0);
        nx_irq = 32'h4; step();
        wait_msi(20, c, v);
        wait_msi(TO + 100, c2, v2);
        chk("t3_timeout_gap", 32'(c2 - c), 32'(TO + RD + 2));
        chk("t3_timeout_vec", v2, 32'h4);
        respond(c2 + 2, 1, 0);

        // Mask and alias
        nx_mme = 12'd1; nx_mupd = 1; nx_mdata = 32'h2; step();
        n0 = log_cyc.size(); d0 = de_cnt;
        nx_irq = 32'h8; step();
        idle(6);
        chk("t4_masked_no_msi", 32'(log_cyc.size()), 32'(n0));
        chk("t4_pstat_alias", o_ps, 32'h2);
        chk("t4_de_strobes", 32'(de_cnt - d0), 32'd1);
        nx_mupd = 1; nx_mdata = 32'h0; step();
        wait_msi(20, c, v);
        chk("t4_alias_vec", v, 32'h2);
        respond(c + 3, 1, 0);
        idle(2);
        chk("t4_pstat_clear", o_ps, 32'h0);

        // Coalescing, enable gating, re-arm during WAIT
        nx_mme = 12'd5; nx_en = 4'h0; step();
        n0 = log_cyc.size();
        for (int k = 0; k < 3; k++) begin
            nx_irq = 32'h80; step(); idle(2);
        end
        idle(10);
        chk("t5_disabled_no_msi", 32'(log_cyc.size()), 32'(n0));
        nx_en = 4'h1; step();
        wait_msi(20, c, v);
        chk("t5_first_vec", v, 32'h80);
        while (cyc < c + 2) step();
        nx_irq = 32'h80; step();
        m = c + 5;
        respond(m, 1, 0);
        wait_msi(20, c2, v2);
        chk("t5_rearm_vec", v2, 32'h80);
        chk("t5_rearm_gap", 32'(c2 - m), 32'd2);
        respond(c2 + 3, 1, 0);
        idle(10);
        chk("t5_msi_count", 32'(log_cyc.size() - n0), 32'd2);

        // Reset while waiting; late sent ignored
        nx_irq = 32'h8; step();
        wait_msi(20, c, v);
        step();
        nx_rst = 1; step();
        nx_rst = 0; nx_sent = 1; step();
        chk("t6_int_after_rst", o_int, 32'h0);
        step();
        chk("t6_no_late_sent", 32'(o_sent), 32'd0);
        a = cyc; nx_irq = 32'h8; step();
        wait_msi(20, c, v);
        chk("t6_latency", 32'(c - a), 32'd2);
        chk("t6_vector", v, 32'h8);
        respond(c + 5, 1, 0);

        // Randomized traffic
        auto_resp = 1;
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 3) == 0) nx_irq = 32'd1 << $urandom_range(0, N - 1);
            else if ($urandom_range(0, 19) == 0) nx_irq = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 99) == 0) begin
                nx_mupd = 1; nx_mdata = $urandom & $urandom & $urandom;
            end
            if ($urandom_range(0, 199) == 0) nx_mme = 12'($urandom);
            if ($urandom_range(0, 299) == 0) nx_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom) | 4'h1;
            nx_rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        nx_rst = 0;
        step();

        chk("const_outputs", {o_select, o_ps_fn, o_attr, o_tph_present, o_tph_type, o_tph_st_tag, o_fn}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/taxi_pcie_us_msi_req.md
# taxi_pcie_us_msi_req

MSI request generator between the NIC core's interrupt sources and the UltraScale+ PCIe hard block's cfg_interrupt_msi_* interface. It latches per-vector interrupt pulses into a pending register and applies the host-programmed MSI enable, vector count and mask. It issues one MSI at a time with round-robin fairness and handles sent/fail/timeout with retry. Instanced in the pcie_clk domain of fpga_core, driving the same cfg_interrupt_msi_* signals the core exposes.

## Interface
- IRQ_N, 32: number of request vectors (1..32).
- RETRY_DELAY, 16: idle cycles after a fail/timeout before the next issue (>=1).
- TIMEOUT, 1024: cycles to wait for sent/fail before declaring timeout (>=2).

- clk  in  1  PCIe user clock (pcie_clk).
- rst  in  1  synchronous active-high reset.
- irq_req  in  IRQ_N  per-vector request pulses; any high bit sets that pending bit.
- cfg_interrupt_msi_enable  in  4  bit 0 = PF0 MSI enable.
- cfg_interrupt_msi_mmenable  in  12  bits [2:0] = log2 of enabled vector count for PF0.
- cfg_interrupt_msi_mask_update  in  1  mask register changed.
- cfg_interrupt_msi_data  in  32  PF0 mask value, valid while mask_update high.
- cfg_interrupt_msi_select  out  2  constant 0.
- cfg_interrupt_msi_int  out  32  one-hot, single-cycle MSI request.
- cfg_interrupt_msi_sent  in  1  hard IP completed the MSI.
- cfg_interrupt_msi_fail  in  1  hard IP rejected the MSI.
- cfg_interrupt_msi_pending_status  out  32  pending & mask, aliased vectors.
- cfg_interrupt_msi_pending_status_data_enable  out  1  one-cycle strobe on pending_status change.
- cfg_interrupt_msi_pending_status_function_num  out  2  constant 0.
- cfg_interrupt_msi_attr / _tph_present / _tph_type / _tph_st_tag / _function_number  out  3/1/2/8/8  constant 0.
- stat_sent, stat_fail  out  1  one-cycle strobes; stat_fail also pulses on timeout.

## Operation
- Registers: pending[IRQ_N], mask[32], rr_ptr, in-flight index, FSM, counters. All reset to 0.
- Vector alias: issued vector v(i) = i & ((1<<mme)-1), where mme = min(mmenable[2:0], 5).
- Eligible(i) = pending[i] & enable[0] & !mask[v(i)].
- Mask: mask <= cfg_interrupt_msi_data in any cycle mask_update is high.
- FSM IDLE: if any eligible, pick the first eligible index at or after rr_ptr (wrapping), then go to ISSUE.
- FSM ISSUE (one cycle): msi_int = 1<<v(sel). Clear pending[sel]. Set rr_ptr = sel+1 mod IRQ_N. Go to WAIT.
- FSM WAIT: on sent, pulse stat_sent and go to IDLE. On fail, or when the TIMEOUT counter expires, set pending[sel], pulse stat_fail and go to BACKOFF.
  - sent and fail in the same cycle: treated as sent.
  - Counter starts at 0 on WAIT entry; expiry is when count reaches TIMEOUT-1.
- FSM BACKOFF: count RETRY_DELAY cycles, then go to IDLE.
- irq_req while pending: no effect (coalesced).
- irq_req on the in-flight index during WAIT: sets pending, so a second MSI follows. Same on the ISSUE cycle: set wins over clear.
- enable[0] or mask changes during WAIT: do not abort; the FSM still waits for sent/fail/timeout. Pending bits are held while enable is low.
- Pending status: pending_status[k] = OR over i with v(i)=k of (pending[i] & mask[k]). Registered. data_enable pulses the cycle after that value changes.
- Reset mid-operation: returns to IDLE and clears pending/mask/counters. msi_int reads 0 on the next cycle; a late sent/fail is ignored.

## Timing
- Every output is 0 while rst is high and in the first cycle after reset.
- Latency: irq_req high in cycle N sets pending at N+1, and msi_int pulses in cycle N+2 (FSM idle, vector eligible).
- msi_int is high for exactly one cycle per issue. At most one MSI is outstanding.
- Minimum spacing: sent at cycle M allows the next issue at M+2 (IDLE at M+1, ISSUE at M+2).
- Retry: fail at cycle M puts the FSM in BACKOFF for cycles M+1..M+RETRY_DELAY. IDLE follows, with re-issue RETRY_DELAY+2 cycles after M.
- stat_sent and stat_fail pulse in the cycle after sent/fail/timeout is observed.

## Test plan
- Single request: enable=1, mmenable=5, irq_req[3] one cycle -> msi_int=0x8 for exactly one cycle 2 cycles later; sent after 5 cycles -> stat_sent=1, pending=0.
- Round robin: irq_req=0x0000_0031 at once, sent returned 3 cycles after each issue -> msi_int sequence 0x1, 0x10, 0x20; then re-requesting bit 0 and bit 5 together -> 0x1 first (pointer wrapped past 5).
- Fail/retry, RETRY_DELAY=16: irq_req[2], fail 3 cycles after issue -> stat_fail, pending[2]=1, re-issue 0x4 exactly 18 cycles after fail. No sent/fail at all -> timeout after TIMEOUT cycles, same retry.
- Mask/alias: mmenable=1, mask_update with data=0x2, irq_req[3] -> no MSI; pending_status=0x2 with data_enable strobe; mask_update data=0 -> msi_int=0x2 issued, pending_status returns 0.
- Coalesce/re-arm: irq_req[7] pulsed 3 times before issue -> one MSI. irq_req[7] during WAIT -> a second 0x80 after sent. Enable=0 -> nothing issued, pending held until enable=1.
- Reset: assert rst during WAIT -> next cycle all outputs 0. A sent in the following cycle produces no stat_sent. A new irq_req behaves as in the single-request test.
